// File: rtl/drp_arbiter.sv
// drp_arbiter: shares one transceiver DRP port among PORTS requesters.
// Each requester's one-cycle strobe is latched, the shared port is granted
// round-robin one transaction at a time, and a timeout counter guarantees a
// completion pulse even when drp_rdy never arrives.
//
// Handshake: req_en[i] is a one-cycle strobe accepted only while port i has
// nothing pending and is not the granted port in WAIT; every accepted strobe
// gets exactly one req_rdy[i] pulse (with req_do[i] valid in that cycle)
// unless reset intervenes. On the shared side drp_en is a one-cycle pulse and
// the transaction ends on the first drp_rdy seen in WAIT or on timeout.
// The FSM state is visible at the busy output (busy == state is WAIT).
module drp_arbiter #(
  parameter int PORTS      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [PORTS*16-1:0]         req_di,
  input  logic [PORTS-1:0]            req_en,
  input  logic [PORTS-1:0]            req_we,
  output logic [PORTS*16-1:0]         req_do,
  output logic [PORTS-1:0]            req_rdy,
  output logic [ADDR_WIDTH-1:0]       drp_addr,
  output logic [15:0]                 drp_do,
  input  logic [15:0]                 drp_di,
  output logic                        drp_en,
  output logic                        drp_we,
  input  logic                        drp_rdy,
  output logic                        busy,
  output logic                        timeout
);

  localparam int          GW       = $clog2(PORTS);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [PORTS-1:0]      pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q [PORTS];
  logic [ADDR_WIDTH-1:0] lat_addr_d [PORTS];
  logic [15:0]           lat_di_q [PORTS];
  logic [15:0]           lat_di_d [PORTS];
  logic [PORTS-1:0]      lat_we_q, lat_we_d;
  logic [ADDR_WIDTH-1:0] drp_addr_q, drp_addr_d;
  logic [15:0]           drp_do_q, drp_do_d;
  logic                  drp_en_q, drp_en_d;
  logic                  drp_we_q, drp_we_d;
  logic [PORTS*16-1:0]   req_do_q, req_do_d;
  logic [PORTS-1:0]      req_rdy_q, req_rdy_d;
  logic                  timeout_q, timeout_d;

  logic                  sel_found;
  logic [GW-1:0]         sel;

  // Round-robin pick: first pending port searching upward from last+1.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel       = '0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = (int'(last_q) + k) % PORTS;
      if (!sel_found && pend_q[idx]) begin
        sel_found = 1'b1;
        sel       = GW'(idx);
      end
    end
  end

  // Next-state logic: request latching, grant issue, completion and timeout.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    lat_addr_d = lat_addr_q;
    lat_di_d   = lat_di_q;
    lat_we_d   = lat_we_q;
    drp_addr_d = drp_addr_q;
    drp_do_d   = drp_do_q;
    drp_en_d   = 1'b0;
    drp_we_d   = 1'b0;
    req_do_d   = req_do_q;
    req_rdy_d  = '0;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // drp_rdy here is a stray and is deliberately not looked at.
        if (sel_found) begin
          grant_d      = sel;
          last_d       = sel;
          pend_d[sel]  = 1'b0;
          drp_addr_d   = lat_addr_q[sel];
          drp_do_d     = lat_di_q[sel];
          drp_we_d     = lat_we_q[sel];
          drp_en_d     = 1'b1;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real answer beats a simultaneous counter expiry.
        if (drp_rdy) begin
          req_do_d[int'(grant_q)*16 +: 16] = drp_di;
          req_rdy_d[grant_q]               = 1'b1;
          state_d                          = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_do_d[int'(grant_q)*16 +: 16] = 16'hFFFF;
          req_rdy_d[grant_q]               = 1'b1;
          timeout_d                        = 1'b1;
          state_d                          = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe on a port that is pending or currently in flight is dropped.
    for (int i = 0; i < PORTS; i++) begin
      if (req_en[i] && !pend_q[i] &&
          !(state_q == S_WAIT && int'(grant_q) == i)) begin
        pend_d[i]     = 1'b1;
        lat_addr_d[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        lat_di_d[i]   = req_di[i*16 +: 16];
        lat_we_d[i]   = req_we[i];
      end
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= GW'(PORTS - 1);
      cnt_q      <= '0;
      pend_q     <= '0;
      for (int i = 0; i < PORTS; i++) begin
        lat_addr_q[i] <= '0;
        lat_di_q[i]   <= '0;
      end
      lat_we_q   <= '0;
      drp_addr_q <= '0;
      drp_do_q   <= '0;
      drp_en_q   <= 1'b0;
      drp_we_q   <= 1'b0;
      req_do_q   <= '0;
      req_rdy_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      lat_addr_q <= lat_addr_d;
      lat_di_q   <= lat_di_d;
      lat_we_q   <= lat_we_d;
      drp_addr_q <= drp_addr_d;
      drp_do_q   <= drp_do_d;
      drp_en_q   <= drp_en_d;
      drp_we_q   <= drp_we_d;
      req_do_q   <= req_do_d;
      req_rdy_q  <= req_rdy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign drp_addr = drp_addr_q;
  assign drp_do   = drp_do_q;
  assign drp_en   = drp_en_q;
  assign drp_we   = drp_we_q;
  assign req_do   = req_do_q;
  assign req_rdy  = req_rdy_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_drp_arbiter.sv
// tb_drp_arbiter: scoreboard bench for drp_arbiter (2 ports, TIMEOUT 16).
// A behavioural DRP slave answers a programmable number of cycles after
// each drp_en; expected grants and responses are queued as requests are
// driven and checked when the DUT issues drp_en / req_rdy.
module tb_drp_arbiter;

  localparam int PORTS = 2;
  localparam int AW    = 10;
  localparam int TO    = 16;

  logic                 clk;
  logic                 rst;
  logic [PORTS*AW-1:0]  req_addr;
  logic [PORTS*16-1:0]  req_di;
  logic [PORTS-1:0]     req_en;
  logic [PORTS-1:0]     req_we;
  logic [PORTS*16-1:0]  req_do;
  logic [PORTS-1:0]     req_rdy;
  logic [AW-1:0]        drp_addr;
  logic [15:0]          drp_do;
  logic [15:0]          drp_di;
  logic                 drp_en;
  logic                 drp_we;
  logic                 drp_rdy;
  logic                 busy;
  logic                 timeout;

  drp_arbiter #(.PORTS(PORTS), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_di(req_di), .req_en(req_en), .req_we(req_we),
    .req_do(req_do), .req_rdy(req_rdy),
    .drp_addr(drp_addr), .drp_do(drp_do), .drp_di(drp_di),
    .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(drp_rdy),
    .busy(busy), .timeout(timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // grant entry: {addr[9:0], we, di[15:0]}
  logic [26:0] exp_g_q[$];
  // response entry: {port, timeout, data[15:0], latency[7:0]}
  logic [25:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rr_last  = PORTS - 1;

  // DRP slave model controls
  int          resp_delay = -1;
  logic        use_addr   = 1'b0;
  logic [15:0] rd_data    = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [AW-1:0] a);
    return use_addr ? (16'hC000 | {6'h0, a}) : rd_data;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic [AW-1:0] a, input logic we,
                         input logic [15:0] di);
    req_addr[p*AW +: AW] = a;
    req_we[p]            = we;
    req_di[p*16 +: 16]   = di;
  endtask

  task automatic push_txn(input int p, input logic [AW-1:0] a, input logic we,
                          input logic [15:0] di, input logic to,
                          input logic [15:0] data, input int lat);
    exp_g_q.push_back({a, we, di});
    exp_q.push_back({p[0], to, data, lat[7:0]});
    rr_last = p;
  endtask

  // Called at posedge+1; strobes the mask for exactly one cycle.
  task automatic fire(input logic [PORTS-1:0] mask);
    req_en = mask;
    @(posedge clk); #1;
    req_en = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_g_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      check("wait_budget", 32'd1, 32'd0);
      exp_q.delete();
      exp_g_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- DRP slave model ----------------
  initial begin
    int cd;
    logic [AW-1:0] addr_s;
    cd      = -1;
    addr_s  = '0;
    drp_rdy = 1'b0;
    drp_di  = 16'h0;
    forever begin
      @(posedge clk); #1;
      drp_rdy = 1'b0;
      if (rst) begin
        cd = -1;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            drp_rdy = 1'b1;
            drp_di  = model_data(addr_s);
            cd      = -1;
          end
        end
        if (drp_en) begin
          cd     = resp_delay;
          addr_s = drp_addr;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int cyc, en_cyc, outstanding, p;
    logic [26:0] g;
    logic [25:0] e;
    cyc = 0; en_cyc = 0; outstanding = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        outstanding = 0;
      end else begin
        if (drp_en) begin
          check("one_outstanding", outstanding, 0);
          check("busy_on_en", {31'd0, busy}, 32'd1);
          if (exp_g_q.size() == 0) begin
            check("en_unexpected", {31'd0, drp_en}, 32'd0);
          end else begin
            g = exp_g_q.pop_front();
            check("drp_addr", {22'd0, drp_addr}, {22'd0, g[26:17]});
            check("drp_we", {31'd0, drp_we}, {31'd0, g[16]});
            check("drp_do", {16'd0, drp_do}, {16'd0, g[15:0]});
          end
          outstanding = 1;
          en_cyc      = cyc;
        end else begin
          check("we_outside_en", {31'd0, drp_we}, 32'd0);
        end
        if (req_rdy != '0) begin
          if (exp_q.size() == 0) begin
            check("rdy_unexpected", {30'd0, req_rdy}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            p = int'(e[25]);
            check("rdy_port", {30'd0, req_rdy}, 32'd1 << p);
            check("req_do", {16'd0, req_do[p*16 +: 16]}, {16'd0, e[23:8]});
            check("timeout_flag", {31'd0, timeout}, {31'd0, e[24]});
            check("rdy_latency", cyc - en_cyc, {24'd0, e[7:0]});
          end
          outstanding = 0;
        end else begin
          check("timeout_without_rdy", {31'd0, timeout}, 32'd0);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n, guard, first;
    rst      = 1'b1;
    req_addr = '0;
    req_di   = '0;
    req_en   = '0;
    req_we   = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", {30'd0, req_rdy}, 32'd0);
    check("rst_req_do", req_do, 32'd0);
    check("rst_drp_en", {31'd0, drp_en}, 32'd0);
    check("rst_drp_addr", {22'd0, drp_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // simultaneous writes: port 0 first after reset, then port 1
    resp_delay = 2; use_addr = 1'b0; rd_data = 16'h0000;
    set_req(0, 10'h010, 1'b1, 16'hAAAA);
    set_req(1, 10'h020, 1'b1, 16'h5555);
    push_txn(0, 10'h010, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 3);
    push_txn(1, 10'h020, 1'b1, 16'h5555, 1'b0, 16'h0000, 3);
    fire(2'b11);
    wait_idle(200);

    // single read, with a dropped re-strobe while port 0 is in flight
    resp_delay = 3; rd_data = 16'h1234;
    set_req(0, 10'h05A, 1'b0, 16'h0000);
    push_txn(0, 10'h05A, 1'b0, 16'h0000, 1'b0, 16'h1234, 4);
    fire(2'b01);
    @(posedge clk); #1;
    set_req(0, 10'h3FF, 1'b1, 16'hDEAD);
    fire(2'b01);
    wait_idle(200);

    // round-robin fairness: both re-request right after each req_rdy
    resp_delay = int'($urandom_range(1, 4)); use_addr = 1'b1;
    first = (rr_last + 1) % PORTS;
    for (int k = 0; k < 2; k++) begin
      int p;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic w;
      p = (first + k) % PORTS;
      a = AW'($urandom_range(0, 1023));
      d = 16'($urandom_range(0, 65535));
      w = 1'($urandom_range(0, 1));
      set_req(p, a, w, d);
      push_txn(p, a, w, d, 1'b0, model_data(a), resp_delay + 1);
    end
    fire(2'b11);
    n = 2; guard = 0;
    while (n < 8 && guard < 400) begin
      @(posedge clk); #1;
      req_en = '0;
      guard++;
      for (int p = 0; p < PORTS; p++) begin
        if (req_rdy[p] && n < 8) begin
          logic [AW-1:0] a;
          logic [15:0] d;
          logic w;
          a = AW'($urandom_range(0, 1023));
          d = 16'($urandom_range(0, 65535));
          w = 1'($urandom_range(0, 1));
          set_req(p, a, w, d);
          push_txn(p, a, w, d, 1'b0, model_data(a), resp_delay + 1);
          req_en[p] = 1'b1;
          n++;
        end
      end
    end
    @(posedge clk); #1;
    req_en = '0;
    if (guard >= 400) check("fair_budget", 32'd1, 32'd0);
    wait_idle(400);

    // timeout: slave never answers; pending port 1 is issued afterwards
    resp_delay = -1; use_addr = 1'b0;
    set_req(0, 10'h0AA, 1'b0, 16'h0000);
    push_txn(0, 10'h0AA, 1'b0, 16'h0000, 1'b1, 16'hFFFF, TO);
    fire(2'b01);
    repeat (2) @(posedge clk);
    #1;
    set_req(1, 10'h0BB, 1'b0, 16'h0000);
    push_txn(1, 10'h0BB, 1'b0, 16'h0000, 1'b1, 16'hFFFF, TO);
    fire(2'b10);
    wait_idle(200);

    // drp_rdy in the same cycle the counter expires: data wins
    resp_delay = TO - 1; rd_data = 16'h00C3;
    set_req(0, 10'h0C3, 1'b0, 16'h0000);
    push_txn(0, 10'h0C3, 1'b0, 16'h0000, 1'b0, 16'h00C3, TO);
    fire(2'b01);
    wait_idle(200);

    // reset mid-transaction with port 1 pending
    resp_delay = -1;
    set_req(0, 10'h100, 1'b0, 16'h0000);
    exp_g_q.push_back({10'h100, 1'b0, 16'h0000});
    fire(2'b01);
    repeat (2) @(posedge clk);
    #1;
    set_req(1, 10'h200, 1'b1, 16'h1111);
    fire(2'b10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_req_rdy", {30'd0, req_rdy}, 32'd0);
    check("midrst_req_do", req_do, 32'd0);
    check("midrst_drp_en", {31'd0, drp_en}, 32'd0);
    check("midrst_drp_addr", {22'd0, drp_addr}, 32'd0);
    check("midrst_drp_do", {16'd0, drp_do}, 32'd0);
    check("midrst_timeout", {31'd0, timeout}, 32'd0);
    exp_q.delete();
    exp_g_q.delete();
    rr_last = PORTS - 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (TO + 4) @(posedge clk);
    #1;
    // fresh port 1 request: grant registered at E1, drp_en in the next cycle
    resp_delay = 2; rd_data = 16'h7E57;
    set_req(1, 10'h155, 1'b0, 16'h0000);
    push_txn(1, 10'h155, 1'b0, 16'h0000, 1'b0, 16'h7E57, 3);
    fire(2'b10);
    @(posedge clk); #1;
    check("postrst_en_latency", {31'd0, drp_en}, 32'd1);
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/drp_arbiter.md
# drp_arbiter

Shares a single transceiver DRP port (GTY/GTH channel or common) among `PORTS` independent DRP requesters, e.g. the XFCP GTY DRP module plus local calibration or eye-scan logic. It latches each requester's one-cycle DRP strobe and grants the shared port round-robin, one transaction at a time. It returns the read data and a one-cycle ready to the winning requester. A timeout counter guarantees that a requester can never hang on a missing `drp_rdy`.

## Interface
- `PORTS`, 2: number of requester ports; range 2 to 8.
- `ADDR_WIDTH`, 10: DRP address width.
- `TIMEOUT`, 1024: cycles to wait for `drp_rdy` after issuing `drp_en`; range 2 to 65535.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `req_addr` in `PORTS*ADDR_WIDTH`: per-port address; port i occupies slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_di` in `PORTS*16`: per-port write data.
- `req_en` in `PORTS`: per-port one-cycle request strobe.
- `req_we` in `PORTS`: per-port write enable, qualified by `req_en`.
- `req_do` out `PORTS*16`: per-port read data, valid while `req_rdy[i]` is high.
- `req_rdy` out `PORTS`: per-port one-cycle completion pulse.
- `drp_addr` out `ADDR_WIDTH`: shared DRP address.
- `drp_do` out 16: shared DRP write data.
- `drp_di` in 16: shared DRP read data.
- `drp_en` out 1: shared DRP enable.
- `drp_we` out 1: shared DRP write enable.
- `drp_rdy` in 1: shared DRP ready.
- `busy` out 1: high while a transaction is outstanding on the shared port.
- `timeout` out 1: one-cycle pulse when a transaction is terminated by the timeout.

## Operation
- **Per-port pending latch.**
  - When `req_en[i]` is high and port i has nothing pending, the port stores addr, di and we and sets `pend[i]`.
  - When `req_en[i]` arrives while `pend[i]` is already set, or while port i is the granted port in WAIT, the strobe is ignored (protocol violation); the latch keeps its contents and no response is generated for the dropped strobe.
  - `pend[i]` clears in the cycle port i is granted.
- **FSM state IDLE.**
  - If any `pend` bit is set, select the first pending port searching from `last+1` upward, wrapping modulo `PORTS`.
  - Register the selected port as grant `g`, set `last <= g`, drive `drp_addr`/`drp_do`/`drp_we` from the latch of port g, pulse `drp_en`, and go to WAIT.
  - If nothing is pending, stay in IDLE.
- **FSM state WAIT.**
  - Counter increments every cycle.
  - On `drp_rdy`: `req_do[g] <= drp_di`, pulse `req_rdy[g]`, go to IDLE.
  - Else, when the counter reaches `TIMEOUT-1`: `req_do[g] <= 16'hFFFF`, pulse `req_rdy[g]` and `timeout`, go to IDLE.
  - If `drp_rdy` and counter expiry occur in the same cycle, `drp_rdy` wins: real data is returned and `timeout` is not pulsed.
- **Hold and stray-ready rules.**
  - `drp_addr`, `drp_do` and `drp_we` hold their value until the next grant.
  - `drp_we` is 0 outside the `drp_en` cycle.
  - `drp_rdy` in IDLE is ignored.
- **`busy`** = (state == WAIT).
- **`req_do[i]` for ports other than g** holds its last value.
- **Reset.**
  - Reset may assert mid-transaction. On reset every `pend`, `req_rdy`, `req_do`, `drp_*` output, `busy` and `timeout` is 0, and the FSM enters IDLE.
  - `last` resets to `PORTS-1`, so port 0 has first priority.
  - An interrupted transaction produces no response.

## Timing
- Request strobe `req_en[i]` sampled at edge E0 sets `pend[i]`.
- If the block was in IDLE, the grant is registered at edge E1, and `drp_en` is high for exactly the one cycle after E1.
- `drp_rdy` sampled at edge Ek: `req_rdy[g]` and `req_do[g]` are valid during the cycle after Ek.
- The next grant is registered at edge Ek+1, giving a minimum 1-cycle gap between `drp_en` pulses.
- Minimum request-to-`drp_en` latency: 1 cycle after the request edge.
- A timeout pulse occurs `TIMEOUT` cycles after the `drp_en` cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Single read.** Port 0 strobes addr 0x05A with we=0; the DRP model answers 0x1234 after 3 cycles. Required: exactly one `drp_en` with `drp_addr`=0x05A, then `req_rdy[0]` pulses with `req_do[0]`=0x1234, and `req_rdy[1]` stays 0.
- **Simultaneous requests.** Ports 0 and 1 strobe writes in the same cycle, port 0 with addr 0x010 data 0xAAAA and port 1 with addr 0x020 data 0x5555. Required: port 0 is served first and then port 1, with `drp_we`=1 on both `drp_en` cycles and only one `drp_en` outstanding at a time.
- **Round-robin fairness.** Both ports re-request immediately after each `req_rdy`, for 8 transactions. Required: grants alternate 0,1,0,1,... with no starvation.
- **Timeout.** `TIMEOUT`=16 and the DRP model never answers. Required: `req_rdy` and `timeout` pulse 16 cycles after `drp_en`, `req_do`=0xFFFF, and the next pending request is then issued.
- **Ready versus timeout in the same cycle.** `drp_rdy` arrives in the same cycle the counter expires, with `drp_di`=0x00C3. Required: `req_do`=0x00C3 and `timeout` stays 0.
- **Reset mid-transaction.** Assert `rst` during WAIT with port 1 pending. Required: all outputs go to 0 immediately and no `req_rdy` pulse follows. After release, a new port 1 request gets a grant at E1 with the expected latency.
